// File: rtl/uc_pkg.sv
// uc_pkg: ISA opcode constants, FSM states and control vector shared by the control unit.
package uc_pkg;
  localparam int ALU_BIT = 5;
  localparam logic [3:0] OP_LI = 4'b0000;
  localparam logic [3:0] OP_NOP = 4'b0001;
  localparam logic [5:0] OP_J = 6'b010000;
  localparam logic [5:0] OP_JZ = 6'b010001;
  localparam logic [5:0] OP_JNZ = 6'b010010;
  localparam logic [5:0] OP_HALT = 6'b010011;
  localparam logic [2:0] ALU_NONE = 3'b000;
  typedef enum logic {RUN, HALTED} state_t;
  typedef struct packed {
    logic s_inc;
    logic s_inm;
    logic we3;
    logic wez;
    logic [2:0] op;
  } ctrl_t;
  localparam ctrl_t CTRL_HOLD = '{s_inc: 1'b0, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, op: ALU_NONE};
endpackage

// File: rtl/uc_decode.sv
// uc_decode: combinational Opcode/z to control vector and instruction class flags.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] Opcode,
  input  logic       z,
  output ctrl_t      ctrl,
  output logic       is_illegal,
  output logic       is_halt,
  output logic       is_taken
);
  logic is_alu, is_li, is_nop, is_j, is_jz, is_jnz;
  assign is_alu = Opcode[ALU_BIT];
  assign is_li = Opcode[5:2] == OP_LI;
  assign is_nop = Opcode[5:2] == OP_NOP;
  assign is_j = Opcode == OP_J;
  assign is_jz = Opcode == OP_JZ;
  assign is_jnz = Opcode == OP_JNZ;
  assign is_halt = Opcode == OP_HALT;
  assign is_taken = is_j || (is_jz && z) || (is_jnz && !z);
  assign is_illegal = !(is_alu || is_li || is_nop || is_j || is_jz || is_jnz || is_halt);
  // HALT is a jump-to-self, so it reloads the PC like a taken jump
  assign ctrl.s_inc = !(is_taken || is_halt);
  assign ctrl.s_inm = is_li;
  assign ctrl.we3 = is_alu || is_li;
  assign ctrl.wez = is_alu;
  assign ctrl.op = is_alu ? Opcode[4:2] : ALU_NONE;
endmodule

// File: rtl/uc.sv
// uc: sequencing control unit with sticky halt, illegal-opcode flag and saturating debug counters.
module uc
  import uc_pkg::*;
#(
  parameter int RET_W = 16,
  parameter int JMP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             halted,
  output logic             illegal,
  output logic [RET_W-1:0] retired,
  output logic [JMP_W-1:0] jumps
);
  state_t state, state_nx;
  ctrl_t dec, ctrl;
  logic is_illegal, is_halt, is_taken, run;
  uc_decode u_decode (
    .Opcode(Opcode),
    .z(z),
    .ctrl(dec),
    .is_illegal(is_illegal),
    .is_halt(is_halt),
    .is_taken(is_taken)
  );
  assign run = state == RUN;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= RUN;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (run && is_halt) state_nx = HALTED;
  end
  assign ctrl = run ? dec : CTRL_HOLD;
  assign s_inc = ctrl.s_inc;
  assign s_inm = ctrl.s_inm;
  assign we3 = ctrl.we3;
  assign wez = ctrl.wez;
  assign Op = ctrl.op;
  assign halted = state == HALTED;
  always_ff @(posedge clk or negedge reset)
    if (!reset) illegal <= 1'b0;
    else if (run && is_illegal) illegal <= 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) retired <= '0;
    else if (run && !is_halt && retired != '1) retired <= retired + RET_W'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) jumps <= '0;
    else if (run && is_taken && jumps != '1) jumps <= jumps + JMP_W'(1);
endmodule

// File: tb/tb_uc.sv
// tb_uc: scoreboard bench for uc; stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_uc;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] Opcode = 6'b100100;
  logic z = 1'b0;
  logic s_inc, s_inm, we3, wez, halted, illegal;
  logic [2:0] Op;
  logic [15:0] retired;
  logic [7:0] jumps;
  int checks = 0;
  int fails = 0;
  typedef struct {
    string name;
    logic [32:0] v;
  } exp_t;
  exp_t q[$];
  uc #(.RET_W(16), .JMP_W(8)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .halted(halted), .illegal(illegal), .retired(retired), .jumps(jumps)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      logic [32:0] act;
      e = q.pop_front();
      act = {s_inc, s_inm, we3, wez, Op, halted, illegal, retired, jumps};
      checks++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.v);
      end
    end
  task automatic drive(input logic rst_v, input logic [5:0] opc, input logic zz);
    @(posedge clk);
    #1;
    reset = rst_v;
    Opcode = opc;
    z = zz;
  endtask
  // flags = {s_inc, s_inm, we3, wez}
  task automatic expect_out(input string name, input logic [3:0] flags, input logic [2:0] op,
                            input logic h, input logic il, input logic [15:0] r, input logic [7:0] j);
    exp_t e;
    e.name = name;
    e.v = {flags, op, h, il, r, j};
    q.push_back(e);
  endtask
  initial begin
    drive(0, 6'b100100, 0); expect_out("alu_in_reset", 4'b1011, 3'b001, 0, 0, 16'd0, 8'd0);
    drive(1, 6'b100100, 0); expect_out("alu_first", 4'b1011, 3'b001, 0, 0, 16'd0, 8'd0);
    drive(1, 6'b000000, 1); expect_out("li", 4'b1110, 3'b000, 0, 0, 16'd1, 8'd0);
    drive(1, 6'b010001, 1); expect_out("jz_taken", 4'b0000, 3'b000, 0, 0, 16'd2, 8'd0);
    drive(1, 6'b010010, 1); expect_out("jnz_not_taken", 4'b1000, 3'b000, 0, 0, 16'd3, 8'd1);
    drive(1, 6'b010010, 0); expect_out("jnz_taken", 4'b0000, 3'b000, 0, 0, 16'd4, 8'd1);
    drive(1, 6'b010001, 0); expect_out("jz_not_taken", 4'b1000, 3'b000, 0, 0, 16'd5, 8'd2);
    drive(1, 6'b010000, 0); expect_out("j", 4'b0000, 3'b000, 0, 0, 16'd6, 8'd2);
    drive(1, 6'b111100, 0); expect_out("alu_op7", 4'b1011, 3'b111, 0, 0, 16'd7, 8'd3);
    drive(1, 6'b000100, 0); expect_out("nop", 4'b1000, 3'b000, 0, 0, 16'd8, 8'd3);
    drive(1, 6'b011111, 0); expect_out("illegal_op", 4'b1000, 3'b000, 0, 0, 16'd9, 8'd3);
    drive(1, 6'b101000, 0); expect_out("illegal_set", 4'b1011, 3'b010, 0, 1, 16'd10, 8'd3);
    drive(1, 6'b010100, 0); expect_out("illegal_0101", 4'b1000, 3'b000, 0, 1, 16'd11, 8'd3);
    drive(1, 6'b010011, 0); expect_out("halt_cycle", 4'b0000, 3'b000, 0, 1, 16'd12, 8'd3);
    drive(1, 6'b100000, 0); expect_out("halted_alu", 4'b0000, 3'b000, 1, 1, 16'd12, 8'd3);
    drive(1, 6'b010000, 0); expect_out("halted_j", 4'b0000, 3'b000, 1, 1, 16'd12, 8'd3);
    drive(0, 6'b100000, 0); expect_out("reset_mid", 4'b1011, 3'b000, 0, 0, 16'd0, 8'd0);
    drive(1, 6'b000100, 0); expect_out("after_reset", 4'b1000, 3'b000, 0, 0, 16'd0, 8'd0);
    repeat (65533) drive(1, 6'b000100, 0);
    drive(1, 6'b000100, 0); expect_out("ret_fffe", 4'b1000, 3'b000, 0, 0, 16'hFFFE, 8'd0);
    drive(1, 6'b000100, 0); expect_out("ret_ffff", 4'b1000, 3'b000, 0, 0, 16'hFFFF, 8'd0);
    repeat (5) drive(1, 6'b000100, 0);
    drive(1, 6'b010000, 0); expect_out("ret_sat", 4'b0000, 3'b000, 0, 0, 16'hFFFF, 8'd0);
    repeat (253) drive(1, 6'b010000, 0);
    drive(1, 6'b010000, 0); expect_out("jmp_fe", 4'b0000, 3'b000, 0, 0, 16'hFFFF, 8'hFE);
    repeat (45) drive(1, 6'b010000, 0);
    drive(1, 6'b010000, 0); expect_out("jmp_sat", 4'b0000, 3'b000, 0, 0, 16'hFFFF, 8'hFF);
    drive(1, 6'b010011, 0); expect_out("halt_sat", 4'b0000, 3'b000, 0, 0, 16'hFFFF, 8'hFF);
    drive(1, 6'b000100, 0); expect_out("halted_sat", 4'b0000, 3'b000, 1, 0, 16'hFFFF, 8'hFF);
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
